// File: rtl/data_main_mem_ctrl.sv
// rtl/data_main_mem_ctrl.sv - main-memory responder: 128-bit line reads, 32-bit word writes, fixed latency
module data_main_mem_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic              busy,
    output logic              ready,
    output logic [127:0]      line_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              op_rd;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic              accept;
    logic              fire;

    logic [31:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] b0, b1, b2, b3;
    assign b0 = {addr_q[ADDR_W-1:2], 2'd0};
    assign b1 = {addr_q[ADDR_W-1:2], 2'd1};
    assign b2 = {addr_q[ADDR_W-1:2], 2'd2};
    assign b3 = {addr_q[ADDR_W-1:2], 2'd3};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req || wr_req) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                    cnt_nxt   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    fire      = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            busy     <= 1'b0;
            ready    <= 1'b0;
            line_out <= 128'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= (state_nxt != IDLE);
            ready <= (state_nxt == DONE);
            if (accept) begin
                // read wins a collision; the write is simply dropped
                op_rd  <= rd_req;
                addr_q <= addr;
                data_q <= wr_data;
            end
            if (fire && op_rd)
                line_out <= {mem[b0], mem[b1], mem[b2], mem[b3]};
        end
    end

    // backing store is never cleared; an aborted write never lands
    always_ff @(posedge clk) begin
        if (!rst && fire && !op_rd)
            mem[addr_q] <= data_q;
    end

endmodule

// File: tb/tb_data_main_mem_ctrl.sv
// tb/tb_data_main_mem_ctrl.sv - directed scoreboard bench for data_main_mem_ctrl
module tb_data_main_mem_ctrl;

    localparam int AW = 10;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req, wr_req;
    logic [AW-1:0] addr;
    logic [31:0]   wr_data;
    logic          busy, ready;
    logic [127:0]  line_out;

    logic          rd_req1, wr_req1;
    logic [AW-1:0] addr1;
    logic [31:0]   wr_data1;
    logic          busy1, ready1;
    logic [127:0]  line_out1;

    always #5 clk = ~clk;

    data_main_mem_ctrl #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .wr_data(wr_data), .busy(busy), .ready(ready), .line_out(line_out)
    );

    data_main_mem_ctrl #(.ADDR_W(AW), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .rd_req(rd_req1), .wr_req(wr_req1), .addr(addr1),
        .wr_data(wr_data1), .busy(busy1), .ready(ready1), .line_out(line_out1)
    );

    logic [31:0]  model [int];
    logic [127:0] sb [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input int a);
        int b;
        b = a & 1020;
        return {model[b], model[b+1], model[b+2], model[b+3]};
    endfunction

    // one transaction on the LATENCY=4 instance; optional wr_req pulse during WAIT
    task automatic op0(input bit rd, input bit wr, input int a, input logic [31:0] d,
                       input bit pulse, input string tag);
        int n;
        logic [127:0] exp;
        rd_req  = rd;
        wr_req  = wr;
        addr    = AW'(a);
        wr_data = d;
        if (rd) sb.push_back(line_of(a));
        else if (wr) model[a & 1023] = d;
        @(posedge clk); #1;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        addr    = AW'($urandom);
        wr_data = $urandom;
        n = 0;
        while (n < 20 && !ready) begin
            chk({tag, " busy"}, 128'(busy), 128'(1));
            if (pulse && n == 1) begin
                wr_req  = 1'b1;
                addr    = AW'(a);
                wr_data = 32'hBAD0BAD0;
            end else begin
                wr_req = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        wr_req = 1'b0;
        chk({tag, " latency"}, 128'(n), 128'(LAT));
        if (ready && rd && sb.size() > 0) begin
            exp = sb.pop_front();
            chk({tag, " line"}, line_out, exp);
        end
        @(posedge clk); #1;
        chk({tag, " ready width"}, 128'(ready), 128'(0));
    endtask

    initial begin
        int n, prev, seen, cnt_rdy;
        logic [31:0] m1 [4];
        logic [127:0] exp1;

        rst = 1'b1; rd_req = 1'b1; wr_req = 1'b0; addr = 10'd8; wr_data = 32'd0;
        rd_req1 = 1'b0; wr_req1 = 1'b0; addr1 = '0; wr_data1 = 32'd0;

        // 1. reset held two cycles with rd_req high
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst busy", 128'(busy), 128'(0));
            chk("rst ready", 128'(ready), 128'(0));
            chk("rst line", line_out, 128'd0);
        end
        rst = 1'b0; rd_req = 1'b0;
        @(posedge clk); #1;
        chk("post rst busy", 128'(busy), 128'(0));

        // 2. preload and read line latency
        op0(0, 1, 8,  32'h11111111, 0, "pre8");
        op0(0, 1, 9,  32'h22222222, 0, "pre9");
        op0(0, 1, 10, 32'h33333333, 0, "pre10");
        op0(0, 1, 11, 32'h44444444, 0, "pre11");
        op0(1, 0, 10, 32'h0, 0, "rd10");
        chk("rd10 const", line_out, 128'h11111111_22222222_33333333_44444444);

        // 3. write then read same line
        op0(0, 1, 9, 32'hDEADBEEF, 0, "wr9");
        op0(1, 0, 8, 32'h0, 0, "rd8");
        chk("rd8 const", line_out, 128'h11111111_DEADBEEF_33333333_44444444);

        // 4. collision: read wins; wr pulse during WAIT ignored
        for (int i = 4; i < 8; i++) op0(0, 1, i, 32'h04040404 + 32'(i), 0, "pre4");
        op0(1, 1, 4, 32'hBADBAD00, 1, "coll");
        op0(1, 0, 4, 32'h0, 0, "rd4");
        chk("mem4 kept", 128'(line_out[127:96]), 128'(32'h04040408));

        // 5. reset mid-write aborts
        for (int i = 20; i < 24; i++) op0(0, 1, i, 32'h20200000 + 32'(i), 0, "pre20");
        op0(1, 0, 21, 32'h0, 0, "rd20a");
        wr_req = 1'b1; addr = 10'd20; wr_data = 32'hA5A5A5A5;
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort busy", 128'(busy), 128'(0));
        chk("abort ready", 128'(ready), 128'(0));
        chk("abort line", line_out, 128'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        chk("abort no ready", 128'(seen), 128'(0));
        op0(1, 0, 20, 32'h0, 0, "rd20b");

        // 6. LATENCY=1 instance: writes, then continuous reads at top address
        for (int i = 0; i < 4; i++) begin
            m1[i] = $urandom;
            wr_req1 = 1'b1; addr1 = AW'(1020 + i); wr_data1 = m1[i];
            @(posedge clk); #1;
            wr_req1 = 1'b0;
            n = 0;
            while (n < 10 && !ready1) begin
                @(posedge clk); #1;
                n++;
            end
            chk("l1 wr latency", 128'(n), 128'(1));
            @(posedge clk); #1;
        end
        exp1 = {m1[0], m1[1], m1[2], m1[3]};
        rd_req1 = 1'b1; addr1 = 10'd1023;
        prev = -1; cnt_rdy = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (ready1) begin
                cnt_rdy++;
                chk("l1 line", line_out1, exp1);
                if (prev >= 0) chk("l1 period", 128'(c - prev), 128'(3));
                prev = c;
            end
        end
        rd_req1 = 1'b0;
        chk("l1 ready count", 128'(cnt_rdy), 128'(5));
        n = 0;
        while (n < 6 && busy1) begin
            @(posedge clk); #1;
            n++;
        end
        chk("l1 drains", 128'(busy1), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
